// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg -- shared types and encodings for the multicycle MIPS control unit.
//
// Contents:
//   state_t      : the twelve controller states
//   alu_class_t  : what the FSM asks of the ALU decoder (add, sub, or use funct)
//   OP_* / F_*   : opcode and funct field values the controller recognises
//   ALU_*        : 3-bit ALU operation encodings shared with the datapath ALU
//   SRCB_* / PCSRC_* : datapath mux select encodings
//
// Optional feature macro: MC_CTRL_BNE_EN (see mc_ctrl_fsm.sv).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUC_ADD   = 2'd0,
    ALUC_SUB   = 2'd1,
    ALUC_FUNCT = 2'd2
  } alu_class_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  // ALU operation encodings
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec -- combinational ALU operation decoder.
//
// Ports:
//   alu_class      in  what the FSM wants: fixed add, fixed sub, or decode funct
//   funct          in  instr[5:0]
//   alu_op         out ALU operation code; 010 (add) whenever nothing else applies
//   funct_illegal  out high when alu_class asks for funct decode and funct is unknown
module mc_alu_dec
  import mc_ctrl_pkg::*;
#(
  parameter int FUNCT_W  = 6,
  parameter int ALU_OP_W = 3
) (
  input  alu_class_t            alu_class,
  input  logic [FUNCT_W-1:0]    funct,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic                  funct_illegal
);

  always_comb begin
    alu_op        = ALU_OP_W'(ALU_ADD);
    funct_illegal = 1'b0;
    case (alu_class)
      ALUC_ADD: alu_op = ALU_OP_W'(ALU_ADD);
      ALUC_SUB: alu_op = ALU_OP_W'(ALU_SUB);
      ALUC_FUNCT: begin
        case (funct)
          F_ADD:   alu_op = ALU_OP_W'(ALU_ADD);
          F_SUB:   alu_op = ALU_OP_W'(ALU_SUB);
          F_AND:   alu_op = ALU_OP_W'(ALU_AND);
          F_OR:    alu_op = ALU_OP_W'(ALU_OR);
          F_SLT:   alu_op = ALU_OP_W'(ALU_SLT);
          // Unknown funct keeps add so the result is deterministic.
          default: funct_illegal = 1'b1;
        endcase
      end
      default: alu_op = ALU_OP_W'(ALU_ADD);
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm -- multicycle MIPS control unit (Moore FSM).
//
// Sequences FETCH/DECODE/execute/writeback per instruction and drives every
// datapath mux select and write enable, plus the 3-bit ALU operation.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   opcode, funct  instruction fields from the instruction register
//   zero           ALU equality flag, used only for the branch decision
//   iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
//   alu_src_a, alu_src_b, pc_src, pc_en   datapath controls
//   alu_op         ALU operation (never X; 010 when unmapped)
//   illegal_op     one-cycle pulse on an unsupported opcode (DECODE) or funct (EXECUTE)
//   dbg_state      current state register, for observation only
//
// Optional feature macro MC_CTRL_BNE_EN: when defined, opcode 000101 (bne)
// branches on ~zero; when undefined it is treated as an illegal opcode.
//
// Reset forces all outputs to their FETCH values, with pc_en, ir_write,
// reg_write, mem_write and illegal_op held low, so an aborted instruction
// never completes a write.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALU_OP_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OP_W-1:0]      opcode,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 zero,
  output logic                 iord,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_src,
  output logic                 pc_en,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic                 illegal_op,
  output state_t               dbg_state
);

  state_t     state, next_state;
  alu_class_t alu_class;
  logic       pc_write;
  logic       branch;
  logic       taken;
  logic       op_illegal;
  logic       funct_illegal;

  // State register: the only storage in the default build.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

`ifdef MC_CTRL_BNE_EN
  // Remembers whether the branch in flight is bne, so BRANCH can invert zero.
  logic bne_q;

  always_ff @(posedge clk) begin
    if (reset)                 bne_q <= 1'b0;
    else if (state == DECODE)  bne_q <= (opcode == OP_BNE);
  end

  assign taken = bne_q ? ~zero : zero;
`else
  assign taken = zero;
`endif

  // Next-state and Moore outputs.
  always_comb begin
    next_state = FETCH;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_src     = PCSRC_ALU;
    pc_write   = 1'b0;
    branch     = 1'b0;
    alu_class  = ALUC_ADD;
    op_illegal = 1'b0;

    case (state)
      FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        next_state = DECODE;
      end
      DECODE: begin
        // Branch target computed speculatively into ALUOut.
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECUTE;
          OP_BEQ:       next_state = BRANCH;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       next_state = BRANCH;
`endif
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default: begin
            op_illegal = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord       = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_REG;
        alu_class  = ALUC_FUNCT;
        // Unknown funct still proceeds to ALUWB with an add result.
        next_state = ALUWB;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_class = ALUC_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
      end
      ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
      end
      JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: next_state = FETCH;
    endcase

    // Reset overrides everything with FETCH values minus the write enables.
    if (reset) begin
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_FOUR;
      pc_src     = PCSRC_ALU;
      pc_write   = 1'b0;
      branch     = 1'b0;
      alu_class  = ALUC_ADD;
      op_illegal = 1'b0;
    end
  end

  mc_alu_dec #(
    .FUNCT_W  (FUNCT_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_alu_dec (
    .alu_class     (alu_class),
    .funct         (funct),
    .alu_op        (alu_op),
    .funct_illegal (funct_illegal)
  );

  assign pc_en      = pc_write | (branch & taken);
  assign illegal_op = op_illegal | funct_illegal;
  assign dbg_state  = state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm -- directed testbench for mc_ctrl_fsm.
//
// Output vector layout used by the expected constants (bit 15 .. bit 0):
//   iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
//   alu_src_b[1:0], pc_src[1:0], pc_en, alu_op[2:0], illegal_op
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, pc_en, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;
  state_t     dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  mc_ctrl_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .iord       (iord),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .pc_en      (pc_en),
    .alu_op     (alu_op),
    .illegal_op (illegal_op),
    .dbg_state  (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                alu_src_b, pc_src, pc_en, alu_op, illegal_op};

  // Hand-derived expected output vectors.
  localparam logic [15:0] V_FETCH   = 16'b0_0_1_0_0_0_0_01_00_1_010_0;
  localparam logic [15:0] V_RESET   = 16'b0_0_0_0_0_0_0_01_00_0_010_0;
  localparam logic [15:0] V_DECODE  = 16'b0_0_0_0_0_0_0_11_00_0_010_0;
  localparam logic [15:0] V_DEC_ILL = 16'b0_0_0_0_0_0_0_11_00_0_010_1;
  localparam logic [15:0] V_MEMADR  = 16'b0_0_0_0_0_0_1_10_00_0_010_0;
  localparam logic [15:0] V_MEMRD   = 16'b1_0_0_0_0_0_0_00_00_0_000_0;
  localparam logic [15:0] V_MEMWB   = 16'b0_0_0_0_1_1_0_00_00_0_000_0;
  localparam logic [15:0] V_MEMWR   = 16'b1_1_0_0_0_0_0_00_00_0_000_0;
  localparam logic [15:0] V_EXEC0   = 16'b0_0_0_0_0_0_1_00_00_0_000_0;
  localparam logic [15:0] V_EX_ILL  = 16'b0_0_0_0_0_0_1_00_00_0_010_1;
  localparam logic [15:0] V_ALUWB   = 16'b0_0_0_1_0_1_0_00_00_0_000_0;
  localparam logic [15:0] V_ADDIWB  = 16'b0_0_0_0_0_1_0_00_00_0_000_0;
  localparam logic [15:0] V_BR_T    = 16'b0_0_0_0_0_0_1_00_01_1_110_0;
  localparam logic [15:0] V_BR_N    = 16'b0_0_0_0_0_0_1_00_01_0_110_0;
  localparam logic [15:0] V_JUMP    = 16'b0_0_0_0_0_0_0_00_10_1_000_0;
  // alu_op is not prescribed in pure memory/writeback/jump states.
  localparam logic [15:0] M_ALL     = 16'hFFFF;
  localparam logic [15:0] M_NOALU   = 16'hFFF1;

  task automatic test_reset();
    state_t      es[5] = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB};
    logic [15:0] ev[5] = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB};
    logic [15:0] em[5] = '{M_ALL, M_ALL, M_ALL, M_NOALU, M_NOALU};
    reset = 1'b1; opcode = OP_LW; funct = 6'd0; zero = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (dbg_state !== FETCH) begin
        n_fail++; $display("FAIL reset_state[%0d]: got %0d want %0d", c, dbg_state, FETCH);
      end
      n_checks++;
      if (obs !== V_RESET) begin
        n_fail++; $display("FAIL reset_outputs[%0d]: got %b want %b", c, obs, V_RESET);
      end
    end
    reset = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (dbg_state !== es[i]) begin
        n_fail++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, dbg_state, es[i]);
      end
      n_checks++;
      if ((obs & em[i]) !== (ev[i] & em[i])) begin
        n_fail++; $display("FAIL lw_outputs[%0d]: got %b want %b", i, obs & em[i], ev[i] & em[i]);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (dbg_state !== FETCH) begin
      n_fail++; $display("FAIL lw_return: got %0d want %0d", dbg_state, FETCH);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn[5]  = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    logic [2:0] exp[5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    for (int k = 0; k < 5; k++) begin
      state_t      es[4] = '{FETCH, DECODE, EXECUTE, ALUWB};
      logic [15:0] ev[4] = '{V_FETCH, V_DECODE, V_EXEC0 | {12'd0, exp[k], 1'b0}, V_ALUWB};
      logic [15:0] em[4] = '{M_ALL, M_ALL, M_ALL, M_NOALU};
      opcode = OP_RTYPE; funct = fn[k]; zero = 1'b0; #1;
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (dbg_state !== es[i]) begin
          n_fail++; $display("FAIL rtype%0d_state[%0d]: got %0d want %0d", k, i, dbg_state, es[i]);
        end
        n_checks++;
        if ((obs & em[i]) !== (ev[i] & em[i])) begin
          n_fail++; $display("FAIL rtype%0d_outputs[%0d]: got %b want %b", k, i, obs & em[i], ev[i] & em[i]);
        end
        @(posedge clk); #1;
      end
      n_checks++;
      if (dbg_state !== FETCH) begin
        n_fail++; $display("FAIL rtype%0d_return: got %0d want %0d", k, dbg_state, FETCH);
      end
    end
  endtask

  task automatic test_addi_sw_jump();
    // Three instructions back to back; each row is one cycle.
    state_t      es[11] = '{FETCH, DECODE, ADDIEX, ADDIWB,
                            FETCH, DECODE, MEMADR, MEMWR,
                            FETCH, DECODE, JUMP};
    logic [15:0] ev[11] = '{V_FETCH, V_DECODE, V_MEMADR, V_ADDIWB,
                            V_FETCH, V_DECODE, V_MEMADR, V_MEMWR,
                            V_FETCH, V_DECODE, V_JUMP};
    logic [15:0] em[11] = '{M_ALL, M_ALL, M_ALL, M_NOALU,
                            M_ALL, M_ALL, M_ALL, M_NOALU,
                            M_ALL, M_ALL, M_NOALU};
    logic [5:0]  op[11] = '{OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI,
                            OP_SW, OP_SW, OP_SW, OP_SW,
                            OP_J, OP_J, OP_J};
    funct = 6'd0; zero = 1'b1;
    for (int i = 0; i < 11; i++) begin
      opcode = op[i]; #1;
      n_checks++;
      if (dbg_state !== es[i]) begin
        n_fail++; $display("FAIL b2b_state[%0d]: got %0d want %0d", i, dbg_state, es[i]);
      end
      n_checks++;
      if ((obs & em[i]) !== (ev[i] & em[i])) begin
        n_fail++; $display("FAIL b2b_outputs[%0d]: got %b want %b", i, obs & em[i], ev[i] & em[i]);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (dbg_state !== FETCH) begin
      n_fail++; $display("FAIL b2b_return: got %0d want %0d", dbg_state, FETCH);
    end
  endtask

  task automatic test_branch(input logic [5:0] op, input logic z, input logic [15:0] v_br,
                             input int tag);
    state_t      es[3] = '{FETCH, DECODE, BRANCH};
    logic [15:0] ev[3] = '{V_FETCH, V_DECODE, v_br};
    opcode = op; funct = 6'd0; zero = z; #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dbg_state !== es[i]) begin
        n_fail++; $display("FAIL branch%0d_state[%0d]: got %0d want %0d", tag, i, dbg_state, es[i]);
      end
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++; $display("FAIL branch%0d_outputs[%0d]: got %b want %b", tag, i, obs, ev[i]);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (dbg_state !== FETCH) begin
      n_fail++; $display("FAIL branch%0d_return: got %0d want %0d", tag, dbg_state, FETCH);
    end
  endtask

  task automatic test_illegal_opcode(input logic [5:0] op, input int tag);
    opcode = op; funct = 6'd0; zero = 1'b0; #1;
    n_checks++;
    if (obs !== V_FETCH) begin
      n_fail++; $display("FAIL illop%0d_fetch: got %b want %b", tag, obs, V_FETCH);
    end
    @(posedge clk); #1;
    n_checks++;
    if (dbg_state !== DECODE || obs !== V_DEC_ILL) begin
      n_fail++; $display("FAIL illop%0d_decode: got %0d/%b want %0d/%b", tag, dbg_state, obs, DECODE, V_DEC_ILL);
    end
    @(posedge clk); #1;
    n_checks++;
    if (dbg_state !== FETCH || obs !== V_FETCH) begin
      n_fail++; $display("FAIL illop%0d_return: got %0d/%b want %0d/%b", tag, dbg_state, obs, FETCH, V_FETCH);
    end
  endtask

  task automatic test_illegal_funct();
    state_t      es[4] = '{FETCH, DECODE, EXECUTE, ALUWB};
    logic [15:0] ev[4] = '{V_FETCH, V_DECODE, V_EX_ILL, V_ALUWB};
    logic [15:0] em[4] = '{M_ALL, M_ALL, M_ALL, M_NOALU};
    opcode = OP_RTYPE; funct = 6'b000111; zero = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dbg_state !== es[i]) begin
        n_fail++; $display("FAIL illfn_state[%0d]: got %0d want %0d", i, dbg_state, es[i]);
      end
      n_checks++;
      if ((obs & em[i]) !== (ev[i] & em[i])) begin
        n_fail++; $display("FAIL illfn_outputs[%0d]: got %b want %b", i, obs & em[i], ev[i] & em[i]);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (dbg_state !== FETCH) begin
      n_fail++; $display("FAIL illfn_return: got %0d want %0d", dbg_state, FETCH);
    end
  endtask

  task automatic test_reset_mid_sw();
    opcode = OP_SW; funct = 6'd0; zero = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (dbg_state !== MEMWR || obs[15:14] !== 2'b11) begin
      n_fail++; $display("FAIL midrst_reach_memwr: got %0d/%b want %0d/11", dbg_state, obs[15:14], MEMWR);
    end
    reset = 1'b1; #1;
    n_checks++;
    if (obs !== V_RESET) begin
      n_fail++; $display("FAIL midrst_outputs: got %b want %b", obs, V_RESET);
    end
    @(posedge clk); #1;
    n_checks++;
    if (dbg_state !== FETCH || obs !== V_RESET) begin
      n_fail++; $display("FAIL midrst_fetch: got %0d/%b want %0d/%b", dbg_state, obs, FETCH, V_RESET);
    end
    reset = 1'b0; #1;
    n_checks++;
    if (obs !== V_FETCH) begin
      n_fail++; $display("FAIL midrst_release: got %b want %b", obs, V_FETCH);
    end
  endtask

  initial begin
    reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
    test_reset();
    test_rtype();
    test_addi_sw_jump();
    test_branch(OP_BEQ, 1'b1, V_BR_T, 0);
    test_branch(OP_BEQ, 1'b0, V_BR_N, 1);
    test_illegal_opcode(6'b111111, 0);
    test_illegal_funct();
`ifdef MC_CTRL_BNE_EN
    test_branch(OP_BNE, 1'b0, V_BR_T, 2);
    test_branch(OP_BNE, 1'b1, V_BR_N, 3);
    // A beq after bne must go back to using zero directly.
    test_branch(OP_BEQ, 1'b0, V_BR_N, 4);
`else
    test_illegal_opcode(OP_BNE, 1);
`endif
    test_reset_mid_sw();
    test_branch(OP_BEQ, 1'b1, V_BR_T, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multicycle MIPS control unit, the producing end of the 3-bit ALU operation interface consumed by the datapath ALU.
- Moore FSM sequences FETCH/DECODE/execute/writeback for each instruction.
- Decodes opcode/funct into alu_op and drives all datapath mux selects and write enables.
- Replaces the single-cycle combinational decoder when the core moves to the multicycle datapath.

Parameters:
OP_W, 6, opcode field width
FUNCT_W, 6, funct field width
ALU_OP_W, 3, ALU operation code width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
opcode  in  OP_W  instr[31:26] from instruction register
funct  in  FUNCT_W  instr[5:0] from instruction register
zero  in  1  ALU equality flag (a == b)
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_write  out  1  data memory write enable
ir_write  out  1  instruction register load
reg_dst  out  1  write register select: 0 = rt, 1 = rd
mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = Data
reg_write  out  1  register file write enable
alu_src_a  out  1  ALU A select: 0 = PC, 1 = A reg
alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
pc_src  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
pc_en  out  1  PC load = pc_write | (branch & taken)
alu_op  out  ALU_OP_W  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
illegal_op  out  1  one-cycle pulse on unsupported opcode/funct

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP. Outputs are pure functions of state, except pc_en (uses zero) and EXECUTE alu_op/illegal_op (use funct).
- Unlisted outputs are 0 in each state.
  - FETCH: ir_write=1, pc_write=1, alu_src_b=01, alu_op=add.
  - DECODE: alu_src_b=11, alu_op=add (branch target into ALUOut).
  - MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=add.
  - MEMRD: iord=1. MEMWB: mem_to_reg=1, reg_write=1. MEMWR: iord=1, mem_write=1.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op from funct.
  - ALUWB: reg_dst=1, reg_write=1. ADDIWB: reg_write=1.
  - BRANCH: alu_src_a=1, alu_op=sub, pc_src=01, branch=1, taken=zero.
  - JUMP: pc_src=10, pc_write=1.
- Transitions:
  - FETCH->DECODE.
  - DECODE by opcode: 100011 lw / 101011 sw -> MEMADR; 000000 -> EXECUTE; 000100 beq -> BRANCH; 001000 addi -> ADDIEX; 000010 j -> JUMP.
  - MEMADR -> MEMRD (lw) or MEMWR (sw). MEMRD->MEMWB. EXECUTE->ALUWB. ADDIEX->ADDIWB. All other states -> FETCH.
- Cycle counts, FETCH inclusive: lw 5; sw, R-type and addi 4; beq and j 3.
- Funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Unknown funct in EXECUTE: alu_op=010 and illegal_op=1 for that cycle.
  - ALUWB is still taken; the result is architecturally undefined but deterministic.
- Unknown opcode in DECODE: illegal_op=1 that cycle, next state FETCH, no write enables asserted.
- Reset:
  - State register loads FETCH on the clock edge where reset=1.
  - While reset=1, pc_en, ir_write, reg_write, mem_write and illegal_op are forced 0 combinationally.
  - Remaining outputs take FETCH values.
  - Reset mid-instruction aborts it; no partial writeback follows.
- The state register is the only storage. No X ever reaches alu_op; every unmapped case resolves to 010.

Optional Feature:
Macro MC_CTRL_BNE_EN.
- Defined: opcode 000101 (bne) decodes DECODE->BRANCH, and taken = ~zero for that instruction. The opcode is captured in a 1-bit register at DECODE; that register is cleared by reset.
- Undefined: 000101 is illegal (illegal_op pulse, return to FETCH) and taken = zero always.

Decomposition:
Package mc_ctrl_pkg holds:
- state_t enum (12 states);
- opcode and funct localparams;
- alu_op encodings ALU_ADD/SUB/AND/OR/SLT;
- alu_src_b and pc_src encodings.

One combinational sub-module, mc_alu_dec, maps (aluop class: add, sub, funct; funct) -> alu_op plus a funct-illegal flag. The FSM instantiates it once.

Test Plan:
- Reset held 3 cycles, then release with opcode=100011 -> all write enables 0 during reset; states FETCH, DECODE, MEMADR, MEMRD, MEMWB, then FETCH; reg_write=1 and mem_to_reg=1 only in cycle 5.
- R-type, funct=101010 -> EXECUTE drives alu_op=111, alu_src_a=1, alu_src_b=00; ALUWB drives reg_dst=1, reg_write=1; back to FETCH after 4 cycles.
- beq with zero=1, then zero=0 -> BRANCH: pc_en=1 and pc_src=01 in the first case; pc_en=0 in the second; alu_op=110 in both.
- Opcode 111111 -> illegal_op=1 for exactly the DECODE cycle, no writes, FETCH next cycle. Repeat with R-type funct=000111 -> illegal_op in EXECUTE, alu_op=010.
- sw with reset asserted in MEMWR -> mem_write=0 in that cycle; FETCH on the next cycle.
- With MC_CTRL_BNE_EN defined, bne with zero=0 -> pc_en=1. Without it, bne -> illegal_op pulse.
